aes_out_serializer: RTL

Downstream stage of aes_cipher_top. Captures each 128-bit ciphertext block on the rising edge of the cipher's done and buffers it in a small block FIFO. It then streams each block out as four 32-bit words over a valid/ready interface towards the bus/DMA side. Lets the cipher start the next block while the consumer drains the previous one, and reports dropped blocks.

---
 rtl/aes_out_serializer_if.sv | 27 ++
 rtl/aes_out_serializer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/aes_out_serializer_if.sv
// Word stream from the ciphertext serializer towards the bus/DMA side.
//
// Handshake: a word moves on every rising clk edge where out_valid and
// out_ready are both high. Once out_valid is raised it stays high, and
// out_data/out_last stay stable, until that transfer happens. out_ready may
// change freely and the producer never looks at it before raising out_valid.
// out_last marks the fourth word of a 128-bit block.
interface aes_out_serializer_if;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/aes_out_serializer.sv
// Ciphertext output serializer.
// Captures a 128-bit block on each rising edge of the cipher's done, keeps
// up to FIFO_DEPTH blocks, and streams every block as four 32-bit words.
// Blocks that arrive while the buffer is full (and no slot frees on the same
// edge) are dropped, counted and flagged.
module aes_out_serializer #(
    parameter int FIFO_DEPTH = 2,
    parameter bit MSW_FIRST  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 blk_done,
    input  logic [127:0]         blk_data,
    aes_out_serializer_if.master stream,
    output logic                 fifo_full,
    output logic                 overflow,
    output logic [7:0]           drop_cnt
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [127:0]  mem [FIFO_DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [1:0]    word_idx;
    logic          done_q;

    logic          capture;
    logic          not_empty;
    logic          xfer;
    logic          pop;
    logic          push;
    logic          drop;

    logic [127:0]  head_blk;
    logic [1:0]    word_sel;
    logic [31:0]   head_word;

    // A capture needs done high now and low on the previous edge; done_q
    // resets high so a done already asserted at reset release is ignored.
    assign capture   = blk_done && !done_q;
    assign not_empty = (count != '0);
    assign xfer      = not_empty && stream.out_ready;
    assign pop       = xfer && (word_idx == 2'd3);
    // A full buffer still accepts a block when the head leaves on the same edge.
    assign push      = capture && (!fifo_full || pop);
    assign drop      = capture && fifo_full && !pop;

    // Previous value of done, for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q <= 1'b1;
        end else begin
            done_q <= blk_done;
        end
    end

    // Block storage; written at the tail on every accepted capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[tail] <= blk_data;
        end
    end

    // Occupancy after this edge's push and pop.
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Pointers, occupancy and the registered full flag; pointers wrap
    // naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            fifo_full <= 1'b0;
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            count     <= count_next;
            fifo_full <= (count_next == DEPTH_C);
        end
    end

    // Position of the next word inside the head block.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_idx <= 2'd0;
        end else if (xfer) begin
            word_idx <= word_idx + 2'd1;
        end
    end

    // Sticky drop flag and saturating drop counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
            drop_cnt <= 8'd0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    // Pick the current 32-bit slice of the head block in the chosen order.
    always_comb begin
        head_blk  = mem[head];
        word_sel  = MSW_FIRST ? (2'd3 - word_idx) : word_idx;
        head_word = '0;
        case (word_sel)
            2'd0:    head_word = head_blk[31:0];
            2'd1:    head_word = head_blk[63:32];
            2'd2:    head_word = head_blk[95:64];
            default: head_word = head_blk[127:96];
        endcase
    end

    // Outputs come only from registers, so blk_* never reaches them in the
    // same cycle; data is forced to zero while nothing is buffered.
    assign stream.out_valid = not_empty;
    assign stream.out_data  = not_empty ? head_word : 32'd0;
    assign stream.out_last  = not_empty && (word_idx == 2'd3);

endmodule
